// File: rtl/spi_cmd_decoder.sv
// SPI mode-0 bus snooper: decodes command byte and 24-bit address, steers reads at/above SPLIT_ADDR to the secondary flash.
// Optional macro DECODER_FAST_READ_EN: also treat FAST_READ (0x0B) as a read, with an 8-bit dummy phase.
module spi_cmd_decoder #(
    parameter logic [23:0] SPLIT_ADDR  = 24'h080000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        h_cs_n,
    input  logic        h_sclk,
    input  logic        h_mosi,
    output logic        flash_select,
    output logic [7:0]  cmd,
    output logic [23:0] addr,
    output logic        addr_valid,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_PASS
    } state_t;

`ifdef DECODER_FAST_READ_EN
    localparam logic [5:0] CNT_MAX = 6'd40;
`else
    localparam logic [5:0] CNT_MAX = 6'd32;
`endif

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_cs_prev;
    logic                   r_sclk_prev;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [22:0] r_shift;
    logic        r_flash_select;
    logic [7:0]  r_cmd;
    logic [23:0] r_addr;
    logic        r_addr_valid;
    logic        r_busy;

    logic        w_cs_q;
    logic        w_sclk_q;
    logic        w_mosi_q;
    logic        w_cs_start;
    logic        w_cs_end;
    logic        w_sclk_rise;
    logic [23:0] w_shift_next;
    logic        w_is_read;

    assign w_cs_q   = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_q = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_q = r_mosi_sync[SYNC_STAGES-1];

    assign w_cs_start  = r_cs_prev & ~w_cs_q;
    assign w_cs_end    = ~r_cs_prev & w_cs_q;
    // Edges seen while CS is (synced) high never reach the shifter.
    assign w_sclk_rise = w_sclk_q & ~r_sclk_prev & ~w_cs_q;

    assign w_shift_next = {r_shift, w_mosi_q};

`ifdef DECODER_FAST_READ_EN
    assign w_is_read = (w_shift_next[7:0] == 8'h03) || (w_shift_next[7:0] == 8'h0B);
`else
    assign w_is_read = (w_shift_next[7:0] == 8'h03);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs_sync      <= '1;
            r_sclk_sync    <= '0;
            r_mosi_sync    <= '0;
            r_cs_prev      <= 1'b1;
            r_sclk_prev    <= 1'b0;
            r_state        <= ST_IDLE;
            r_cnt          <= 6'd0;
            r_shift        <= '0;
            r_flash_select <= 1'b0;
            r_cmd          <= 8'h00;
            r_addr         <= 24'h0;
            r_addr_valid   <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_cs_sync    <= {r_cs_sync[SYNC_STAGES-2:0], h_cs_n};
            r_sclk_sync  <= {r_sclk_sync[SYNC_STAGES-2:0], h_sclk};
            r_mosi_sync  <= {r_mosi_sync[SYNC_STAGES-2:0], h_mosi};
            r_cs_prev    <= w_cs_q;
            r_sclk_prev  <= w_sclk_q;
            r_addr_valid <= 1'b0;

            if (w_cs_end && r_state != ST_IDLE) begin
                r_state        <= ST_IDLE;
                r_flash_select <= 1'b0;
                r_busy         <= 1'b0;
                r_cnt          <= 6'd0;
            end else if (r_state == ST_IDLE) begin
                if (w_cs_start) begin
                    r_state <= ST_CMD;
                    r_busy  <= 1'b1;
                    r_cnt   <= 6'd0;
                end
            end else if (w_sclk_rise) begin
                if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + 6'd1;
                end
                case (r_state)
                    ST_CMD: begin
                        r_shift <= w_shift_next[22:0];
                        if (r_cnt == 6'd7) begin
                            r_cmd   <= w_shift_next[7:0];
                            r_state <= w_is_read ? ST_ADDR : ST_PASS;
                        end
                    end
                    ST_ADDR: begin
                        r_shift <= w_shift_next[22:0];
                        if (r_cnt == 6'd31) begin
                            r_addr         <= w_shift_next;
                            r_addr_valid   <= 1'b1;
                            r_flash_select <= (w_shift_next >= SPLIT_ADDR);
`ifdef DECODER_FAST_READ_EN
                            r_state        <= ST_DUMMY;
`else
                            r_state        <= ST_DATA;
`endif
                        end
                    end
                    ST_DUMMY: begin
                        if (r_cnt == 6'd39) begin
                            r_state <= ST_DATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign flash_select = r_flash_select;
    assign cmd          = r_cmd;
    assign addr         = r_addr;
    assign addr_valid   = r_addr_valid;
    assign busy         = r_busy;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Self-checking bench for spi_cmd_decoder: transaction-level reference model plus directed SPI transactions.
module tb_spi_cmd_decoder;

    localparam int          S     = 2;
    localparam logic [23:0] SPLIT = 24'h080000;
`ifdef DECODER_FAST_READ_EN
    localparam logic        FAST  = 1'b1;
`else
    localparam logic        FAST  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        h_cs_n = 1'b1;
    logic        h_sclk = 1'b0;
    logic        h_mosi = 1'b0;
    logic        flash_select;
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic        addr_valid;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_prints = 0;
    int av_cnt   = 0;

    spi_cmd_decoder #(.SPLIT_ADDR(SPLIT), .SYNC_STAGES(S)) dut (
        .clk          (clk),
        .rst          (rst),
        .h_cs_n       (h_cs_n),
        .h_sclk       (h_sclk),
        .h_mosi       (h_mosi),
        .flash_select (flash_select),
        .cmd          (cmd),
        .addr         (addr),
        .addr_valid   (addr_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Reference model: pins seen S clocks late, decoded as a bit list per transaction.
    logic        hist_cs   [S];
    logic        hist_sclk [S];
    logic        hist_mosi [S];
    logic        m_prev_cs = 1'b1;
    logic        m_prev_sclk = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_fs = 1'b0;
    logic        m_av = 1'b0;
    logic [7:0]  m_cmd = 8'h00;
    logic [23:0] m_addr = 24'h0;
    logic [31:0] m_bits = '0;
    int          m_nbits = 0;

    function automatic logic is_read(input logic [7:0] c);
        return (c == 8'h03) || (FAST && c == 8'h0B);
    endfunction

    always @(posedge clk) begin : model
        logic dcs, dsclk, dmosi;
        if (rst) begin
            for (int i = 0; i < S; i++) begin
                hist_cs[i] = 1'b1; hist_sclk[i] = 1'b0; hist_mosi[i] = 1'b0;
            end
            m_prev_cs = 1'b1; m_prev_sclk = 1'b0;
            m_busy = 1'b0; m_fs = 1'b0; m_av = 1'b0;
            m_cmd = 8'h00; m_addr = 24'h0; m_bits = '0; m_nbits = 0;
        end else begin
            dcs = hist_cs[S-1]; dsclk = hist_sclk[S-1]; dmosi = hist_mosi[S-1];
            m_av = 1'b0;
            if (m_busy && dcs && !m_prev_cs) begin
                m_busy = 1'b0;
                m_fs   = 1'b0;
            end else if (!m_busy && !dcs && m_prev_cs) begin
                m_busy = 1'b1; m_nbits = 0; m_bits = '0;
            end else if (m_busy && !dcs && dsclk && !m_prev_sclk && m_nbits < 32) begin
                m_bits = {m_bits[30:0], dmosi};
                m_nbits++;
                if (m_nbits == 8) m_cmd = m_bits[7:0];
                if (m_nbits == 32 && is_read(m_bits[31:24])) begin
                    m_addr = m_bits[23:0];
                    m_av   = 1'b1;
                    m_fs   = (m_bits[23:0] >= SPLIT);
                end
            end
            m_prev_cs = dcs; m_prev_sclk = dsclk;
            for (int i = S - 1; i > 0; i--) begin
                hist_cs[i] = hist_cs[i-1]; hist_sclk[i] = hist_sclk[i-1]; hist_mosi[i] = hist_mosi[i-1];
            end
            hist_cs[0] = h_cs_n; hist_sclk[0] = h_sclk; hist_mosi[0] = h_mosi;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if ({flash_select, addr_valid, busy, cmd, addr} === {m_fs, m_av, m_busy, m_cmd, m_addr}) begin
                n_pass++;
            end else if (n_prints < 30) begin
                n_prints++;
                $display("FAIL cycle_model t=%0t: dut fs=%b av=%b busy=%b cmd=%h addr=%h, required fs=%b av=%b busy=%b cmd=%h addr=%h",
                         $time, flash_select, addr_valid, busy, cmd, addr, m_fs, m_av, m_busy, m_cmd, m_addr);
            end
            if (addr_valid) av_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic send_bits(input logic [63:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            h_mosi = d[63-i];
            repeat (6) @(negedge clk);
            h_sclk = 1'b1;
            repeat (6) @(negedge clk);
            h_sclk = 1'b0;
        end
    endtask

    task automatic txn(input string name, input logic [7:0] c, input logic [23:0] a, input int nbits,
                       input logic exp_fs, input int exp_pulses, input logic [7:0] exp_cmd, input logic [23:0] exp_addr);
        av_cnt = 0;
        h_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        send_bits({c, a, 32'hA5C3_5A3C}, nbits);
        repeat (4) @(negedge clk);
        #1;
        check({name, " fs_before_cs_high"}, 32'(flash_select), 32'(exp_fs));
        check({name, " busy_in_txn"}, 32'(busy), 32'd1);
        @(negedge clk);
        h_cs_n = 1'b1;
        repeat (S + 2) @(negedge clk);
        #1;
        check({name, " fs_after_cs_high"}, 32'(flash_select), 32'd0);
        check({name, " busy_after_cs_high"}, 32'(busy), 32'd0);
        check({name, " addr_valid_pulses"}, 32'(av_cnt), 32'(exp_pulses));
        check({name, " cmd"}, 32'(cmd), 32'(exp_cmd));
        check({name, " addr"}, 32'(addr), 32'(exp_addr));
        $display("txn %s cmd=%h addr=%h bits=%0d -> fs_pre=%b pulses=%0d cmd=%h addr=%h",
                 name, c, a, nbits, exp_fs, av_cnt, cmd, addr);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(negedge clk);
        #1;
        check("reset fs", 32'(flash_select), 32'd0);
        check("reset cmd", 32'(cmd), 32'h00);
        check("reset addr", 32'(addr), 32'h0);
        check("reset addr_valid", 32'(addr_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Reset asserted mid-address phase of a READ
        h_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        send_bits({8'h03, 24'h123456, 32'h0}, 20);
        repeat (4) @(negedge clk);
        #1;
        check("midaddr cmd", 32'(cmd), 32'h03);
        check("midaddr busy", 32'(busy), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst busy", 32'(busy), 32'd0);
        check("async_rst cmd", 32'(cmd), 32'h00);
        check("async_rst fs", 32'(flash_select), 32'd0);
        check("async_rst addr", 32'(addr), 32'h0);
        $display("txn reset_mid_addr -> busy=%b cmd=%h", busy, cmd);
        h_cs_n = 1'b1;
        h_sclk = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        txn("read_000100", 8'h03, 24'h000100, 64, 1'b0, 1, 8'h03, 24'h000100);
        txn("read_split",  8'h03, 24'h080000, 64, 1'b1, 1, 8'h03, 24'h080000);
        txn("read_07ffff", 8'h03, 24'h07FFFF, 64, 1'b0, 1, 8'h03, 24'h07FFFF);
        txn("read_ffffff", 8'h03, 24'hFFFFFF, 64, 1'b1, 1, 8'h03, 24'hFFFFFF);
        txn("write_02",    8'h02, 24'h0A0000, 64, 1'b0, 0, 8'h02, 24'hFFFFFF);
        txn("read_cut20",  8'h03, 24'h090000, 20, 1'b0, 0, 8'h03, 24'hFFFFFF);
        txn("cmd_cut5",    8'h9F, 24'h000000, 5,  1'b0, 0, 8'h03, 24'hFFFFFF);

        // CS rises in the same clk as the 8th sclk rise: that bit must be dropped
        av_cnt = 0;
        h_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        send_bits({8'h9F, 56'h0}, 7);
        h_mosi = 1'b1;
        repeat (6) @(negedge clk);
        h_sclk = 1'b1;
        h_cs_n = 1'b1;
        repeat (6) @(negedge clk);
        h_sclk = 1'b0;
        repeat (S + 4) @(negedge clk);
        #1;
        check("collide cmd", 32'(cmd), 32'h03);
        check("collide busy", 32'(busy), 32'd0);
        check("collide pulses", 32'(av_cnt), 32'd0);
        $display("txn cs_end_vs_sclk_rise -> cmd=%h busy=%b", cmd, busy);
        repeat (4) @(negedge clk);

        txn("fast_dummy", 8'h0B, 24'h100000, 36, FAST, FAST ? 1 : 0, 8'h0B, FAST ? 24'h100000 : 24'hFFFFFF);
        txn("fast_data",  8'h0B, 24'h100000, 64, FAST, FAST ? 1 : 0, 8'h0B, FAST ? 24'h100000 : 24'hFFFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_cmd_decoder.md
Name: spi_cmd_decoder

Overview:
- Snoops the host SPI bus (mode 0) and decodes each transaction's command byte and 24-bit address.
- Drives flash_select into the downstream MISO mux: 0 = main flash, 1 = secondary flash.
- Read commands whose address is at or above SPLIT_ADDR are steered to the secondary flash. All other traffic stays on the main flash.
- All SPI inputs are oversampled in the clk domain; nothing is clocked by h_sclk.

Parameters:
- SPLIT_ADDR, 24'h080000, first address served by the secondary flash.
- SYNC_STAGES, 2, synchronizer depth applied to h_cs_n, h_sclk and h_mosi (minimum 2).

Ports:
- clk  input  1  system clock; must run at least 10x h_sclk.
- rst  input  1  asynchronous reset, active-high.
- h_cs_n  input  1  host chip select, active-low.
- h_sclk  input  1  host SPI clock.
- h_mosi  input  1  host MOSI.
- flash_select  output  1  MISO mux select: 0 = main, 1 = secondary.
- cmd  output  8  last captured command byte.
- addr  output  24  last captured address.
- addr_valid  output  1  one-clk pulse when a read address is fully decoded.
- busy  output  1  high while a transaction is in progress (synced CS low).

Behaviour:
- Reset (rst high): flash_select=0, cmd=8'h00, addr=24'h0, addr_valid=0, busy=0, state=IDLE, bit counter=0. Reset takes effect asynchronously and overrides everything; asserting rst mid-transaction aborts immediately.
- Synchronization:
  - Each input passes through a SYNC_STAGES flop chain.
  - sclk_rise is a one-clk pulse on a synced 0->1 transition of h_sclk.
  - cs_start / cs_end are one-clk pulses on synced falling / rising edges of h_cs_n.
- Bit sampling: MOSI is shifted MSB-first on sclk_rise only. sclk_rise events are ignored while synced CS is high.
- 6-bit bit counter: cleared on cs_start, incremented on every sclk_rise, saturates at 32.
- State machine:
  - IDLE -> CMD on cs_start; busy goes 1.
  - CMD: after the 8th sclk_rise, latch cmd. If cmd is 8'h03 (READ), go to ADDR; otherwise go to PASS.
  - ADDR: after 24 further sclk_rise events, latch addr, pulse addr_valid for 1 clk, and set flash_select = (addr >= SPLIT_ADDR). Go to DATA.
  - DATA: hold flash_select until CS ends.
  - PASS: ignore the bus; flash_select stays 0.
  - Any state except IDLE -> IDLE on cs_end. On that transition: flash_select=0, busy=0, counter cleared. cmd and addr retain their last values.
- Latency:
  - flash_select and addr_valid update on the clk edge after the sclk_rise pulse of the 32nd bit, i.e. SYNC_STAGES+1 clk after the pin edge.
  - At clk >= 10x sclk this is before the first mode-0 data falling edge.
- Boundary cases:
  - CS deasserted mid-CMD or mid-ADDR: no addr_valid, flash_select remains 0, cmd/addr not updated.
  - cs_end and sclk_rise in the same clk: cs_end wins and the bit is discarded.
  - Back-to-back transactions (CS high for >= SYNC_STAGES+2 clk): each is decoded independently.
  - Address compare is unsigned 24-bit. addr == SPLIT_ADDR selects secondary; 24'hFFFFFF selects secondary.
  - Bits beyond 32 (data phase) do not shift into addr or cmd.

Optional Feature:
- Macro DECODER_FAST_READ_EN.
- Defined: cmd 8'h0B (FAST_READ) is also treated as a read. ADDR -> DUMMY state, which counts 8 further sclk_rise events while flash_select is already applied at the end of ADDR. The bit counter widens to saturate at 40. DUMMY -> DATA.
- Undefined: 8'h0B goes to PASS like any non-read command, and flash_select stays 0.

Test Plan:
- Reset during mid-ADDR shifting -> all outputs return to reset values immediately; the next full READ 0x03 @ 0x000100 gives flash_select=0 and one addr_valid pulse, addr=24'h000100.
- READ 0x03 @ 0x080000 (SPLIT_ADDR=24'h080000) -> addr_valid pulse, flash_select=1 until CS high, then 0 within SYNC_STAGES+2 clk.
- READ 0x03 @ 0x07FFFF -> flash_select=0; then READ @ 0xFFFFFF back-to-back -> flash_select=1.
- Write cmd 0x02 @ 0x0A0000 -> cmd=8'h02, no addr_valid, flash_select stays 0, addr unchanged.
- CS raised after 20 bits of READ @ 0x090000 -> no addr_valid, flash_select 0, busy falls.
- FAST_READ 0x0B @ 0x100000: with DECODER_FAST_READ_EN -> flash_select=1 after bit 32 and held through the dummy byte and data; without it -> flash_select 0 throughout.
